// File: rtl/lcd_bus_driver_if.sv
// Request/handshake and LCD bus bundle between the LCD sequencer and the write engine.
interface lcd_bus_driver_if;
    logic [7:0] iDATA;
    logic       iRS;
    logic       iStart;
    logic       oDone;
    logic       oBusy;
    logic [7:0] LCD_DATA;
    logic       LCD_RS;
    logic       LCD_EN;
    logic       LCD_RW;

    modport master (
        output iDATA, iRS, iStart,
        input  oDone, oBusy, LCD_DATA, LCD_RS, LCD_EN, LCD_RW
    );

    modport slave (
        input  iDATA, iRS, iStart,
        output oDone, oBusy, LCD_DATA, LCD_RS, LCD_EN, LCD_RW
    );
endinterface

// File: rtl/lcd_bus_driver.sv
// HD44780-style write engine: RS/DATA setup, EN pulse, hold and execution wait,
// then a one-cycle done pulse back to the sequencer.
//
// state | meaning
// IDLE  | waiting for a rising edge on iStart
// SETUP | RS/DATA driven, EN low
// PULSE | EN high
// HOLD  | EN low, RS/DATA still held
// EXEC  | controller execution wait (short or long)
// DONE  | one-cycle oDone
module lcd_bus_driver #(
    parameter int unsigned SETUP_CYC      = 2,
    parameter int unsigned EN_CYC         = 16,
    parameter int unsigned HOLD_CYC       = 2,
    parameter int unsigned EXEC_SHORT_CYC = 2000,
    parameter int unsigned EXEC_LONG_CYC  = 82000
) (
    input  logic          clk,
    input  logic          rst,
    lcd_bus_driver_if.slave bus
);
    localparam int unsigned MAX_A = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
    localparam int unsigned MAX_B = (HOLD_CYC > MAX_A) ? HOLD_CYC : MAX_A;
    localparam int unsigned MAX_C = (EXEC_SHORT_CYC > MAX_B) ? EXEC_SHORT_CYC : MAX_B;
    localparam int unsigned MAX_P = (EXEC_LONG_CYC > MAX_C) ? EXEC_LONG_CYC : MAX_C;
    localparam int unsigned CW    = $clog2(MAX_P + 1);

    localparam logic [CW-1:0] LD_SETUP = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] LD_EN    = CW'(EN_CYC - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(HOLD_CYC - 1);

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, EXEC, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] exec_len;
    logic          start_q;
    logic          start_edge;
    logic [7:0]    data_q, data_d;
    logic          rs_q, rs_d;
    logic          long_q, long_d;
    logic          en_q, busy_q, done_q;

    assign start_edge = bus.iStart & ~start_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        rs_d     = rs_q;
        long_d   = long_q;
        exec_len = long_q ? CW'(EXEC_LONG_CYC) : CW'(EXEC_SHORT_CYC);
        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    data_d  = bus.iDATA;
                    rs_d    = bus.iRS;
                    // clear (0x01) and home (0x02/0x03) need the long execution wait
                    long_d  = ~bus.iRS && (bus.iDATA[7:2] == 6'd0);
                    state_d = SETUP;
                    cnt_d   = LD_SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = PULSE;
                    cnt_d   = LD_EN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    cnt_d   = LD_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    if (exec_len == '0) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else begin
                        state_d = EXEC;
                        cnt_d   = exec_len - 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Strobes are registered from the next state so they align with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            start_q <= 1'b1;
            data_q  <= 8'd0;
            rs_q    <= 1'b0;
            long_q  <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= bus.iStart;
            data_q  <= data_d;
            rs_q    <= rs_d;
            long_q  <= long_d;
            en_q    <= (state_d == PULSE);
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    assign bus.LCD_DATA = data_q;
    assign bus.LCD_RS   = rs_q;
    assign bus.LCD_EN   = en_q;
    assign bus.LCD_RW   = 1'b0;
    assign bus.oBusy    = busy_q;
    assign bus.oDone    = done_q;
endmodule
